// File: rtl/fc_result_reader.sv
// fc_result_reader
//
// Captures the outputs of a fully connected layer in one cycle and streams
// them out one node per beat, lowest index first.
//
// Optional feature: define FC_ARGMAX_EN to add a signed running maximum over
// the transferred beats, exported on argmax_idx / argmax_val.
//
// Ports
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   start       : capture request (FC layer finished flag); honoured in IDLE only
//   nodes_in    : NUM_NODES words, node k at bits [k*DATA_W +: DATA_W]
//   out_data    : streamed node value
//   out_index   : node index of out_data
//   out_valid   : out_data/out_index/out_last are valid
//   out_ready   : downstream accepts the beat
//   out_last    : current beat is node NUM_NODES-1
//   busy        : state is not IDLE
//   done        : one-cycle pulse after the final beat
//   argmax_idx  : index of the maximum beat (FC_ARGMAX_EN only)
//   argmax_val  : value of the maximum beat (FC_ARGMAX_EN only)
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both 1. While out_valid=1 and out_ready=0, out_data, out_index and
// out_last hold their values; out_valid never drops without a transfer
// except on reset.
module fc_result_reader #(
  parameter int NUM_NODES = 3,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_NODES*DATA_W-1:0] nodes_in,
  output logic [DATA_W-1:0]           out_data,
  output logic [10:0]                 out_index,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
`ifdef FC_ARGMAX_EN
  ,
  output logic [10:0]                 argmax_idx,
  output logic [DATA_W-1:0]           argmax_val
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [10:0] LAST_IDX = 11'(NUM_NODES - 1);

  state_t                        state_q, state_d;
  logic [NUM_NODES*DATA_W-1:0]   buf_q, buf_d;
  logic [10:0]                   idx_q, idx_d;
  logic [DATA_W-1:0]             out_data_q, out_data_d;
  logic                          out_valid_q, out_valid_d;
  logic                          out_last_q, out_last_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          xfer;
  logic [10:0]                   idx_nxt;

`ifdef FC_ARGMAX_EN
  logic [10:0]                   amax_idx_q, amax_idx_d;
  logic [DATA_W-1:0]             amax_val_q, amax_val_d;
`endif

  assign xfer    = out_valid_q & out_ready;
  assign idx_nxt = idx_q + 11'd1;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // The whole vector is frozen here so later changes on nodes_in
          // cannot leak into the stream.
          buf_d       = nodes_in;
          idx_d       = 11'd0;
          out_data_d  = nodes_in[DATA_W-1:0];
          out_valid_d = 1'b1;
          out_last_d  = (LAST_IDX == 11'd0);
          state_d     = S_STREAM;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = S_DONE;
          end else begin
            idx_d       = idx_nxt;
            out_data_d  = buf_q[int'(idx_nxt)*DATA_W +: DATA_W];
            out_last_d  = (idx_nxt == LAST_IDX);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

`ifdef FC_ARGMAX_EN
  // Strictly-greater update keeps the lowest index on ties.
  always_comb begin
    amax_idx_d = amax_idx_q;
    amax_val_d = amax_val_q;
    if (xfer) begin
      if (idx_q == 11'd0 || $signed(out_data_q) > $signed(amax_val_q)) begin
        amax_idx_d = idx_q;
        amax_val_d = out_data_q;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 11'd0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef FC_ARGMAX_EN
      amax_idx_q  <= 11'd0;
      amax_val_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef FC_ARGMAX_EN
      amax_idx_q  <= amax_idx_d;
      amax_val_q  <= amax_val_d;
`endif
    end
  end

  // The capture buffer carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign out_data  = out_data_q;
  assign out_index = idx_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef FC_ARGMAX_EN
  assign argmax_idx = amax_idx_q;
  assign argmax_val = amax_val_q;
`endif

endmodule
